uart_prog_loader: RTL and testbench

UART program loader sitting directly upstream of the memory controller's instruction-memory programming port. While `prog` is high it receives bytes on the `rx` pin and packs every four bytes, little-endian, into one 32-bit instruction word. It writes each word to consecutive instruction-memory word addresses through the `imem_*` write port. It replaces ad-hoc loading inside the core and is clocked from the same 50 MHz domain as `rbus`.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_core.sv | 95 +++++++++
 rtl/uart_prog_loader.sv | 103 ++++++++++
 tb/tb_uart_prog_loader.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receive path and program loader.
// Rev 1.0
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// uart_rx_core: 2-flop rx synchronizer plus 8N1 receive FSM; one-cycle byte/error pulses.
// Rev 1.0
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic  clk,
  input  logic  Rst,
  input  logic  rx,
  output byte_t rx_byte,
  output logic  byte_valid,
  output logic  frame_err_pulse
);

  localparam logic [15:0] C_HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] C_FULL_M1 = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  r_sync;
  logic        r_rx_prev;
  logic        w_rx_s;
  rx_state_t   r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  byte_t       r_shift;

  assign w_rx_s = r_sync[1];

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_sync          <= 2'b11;
      r_rx_prev       <= 1'b1;
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_bit_idx       <= '0;
      r_shift         <= '0;
      rx_byte         <= '0;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
    end else begin
      r_sync          <= {r_sync[0], rx};
      r_rx_prev       <= w_rx_s;
      byte_valid      <= 1'b0;
      frame_err_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_rx_prev && !w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          // A line already back high at mid-start-bit is a glitch, not an error.
          if (r_cnt == C_HALF_M1) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        DATA: begin
          if (r_cnt == C_FULL_M1) begin
            r_cnt     <= '0;
            r_shift   <= {w_rx_s, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        STOP: begin
          if (r_cnt == C_FULL_M1) begin
            r_cnt   <= '0;
            r_state <= IDLE;
            if (w_rx_s) begin
              byte_valid <= 1'b1;
              rx_byte    <= r_shift;
            end else begin
              frame_err_pulse <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packs received UART bytes little-endian into 32-bit words and writes them to imem.
// Rev 1.0
`default_nettype none

module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              rx,
  input  logic              prog,
  output logic              imem_en,
  output logic              imem_prog_ena,
  output logic [ADDR_W-1:0] imem_addr,
  output word_t             imem_din,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              frame_err
);

  localparam logic [ADDR_W:0]   C_LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0]   C_ONE_COUNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] C_ONE_ADDR   = {{(ADDR_W-1){1'b0}}, 1'b1};

  byte_t             w_rx_byte;
  logic              w_byte_valid;
  logic              w_frame_err_pulse;
  logic              r_prog_d;
  logic [1:0]        r_byte_idx;
  word_t             r_word;
  logic [ADDR_W-1:0] r_addr;
  logic              w_prog_rise;
  logic              w_prog_fall;
  logic              w_accept;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk             (clk),
    .Rst             (Rst),
    .rx              (rx),
    .rx_byte         (w_rx_byte),
    .byte_valid      (w_byte_valid),
    .frame_err_pulse (w_frame_err_pulse)
  );

  assign w_prog_rise = prog & ~r_prog_d;
  assign w_prog_fall = ~prog & r_prog_d;
  assign w_accept    = w_byte_valid & prog & ~full & ~w_prog_rise;

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      r_prog_d      <= 1'b0;
      r_byte_idx    <= '0;
      r_word        <= '0;
      r_addr        <= '0;
      imem_en       <= 1'b0;
      imem_prog_ena <= 1'b0;
      imem_addr     <= '0;
      imem_din      <= '0;
      word_count    <= '0;
      full          <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      r_prog_d      <= prog;
      imem_en       <= 1'b0;
      imem_prog_ena <= 1'b0;
      if (w_prog_rise) begin
        r_addr     <= '0;
        r_byte_idx <= '0;
        word_count <= '0;
        full       <= 1'b0;
        frame_err  <= 1'b0;
      end else begin
        if (w_frame_err_pulse) frame_err <= 1'b1;
        if (w_prog_fall) begin
          r_byte_idx <= '0;
        end else if (w_accept) begin
          if (r_byte_idx == 2'd3) begin
            imem_en       <= 1'b1;
            imem_prog_ena <= 1'b1;
            imem_addr     <= r_addr;
            imem_din      <= {w_rx_byte, r_word[23:0]};
            word_count    <= word_count + C_ONE_COUNT;
            r_byte_idx    <= '0;
            // The final slot sets full instead of wrapping the address.
            if (word_count == C_LAST_COUNT) full <= 1'b1;
            else                            r_addr <= r_addr + C_ONE_ADDR;
          end else begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= w_rx_byte;
            r_byte_idx                        <= r_byte_idx + 2'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: random and directed UART traffic against a queue-based word-write model.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_uart_prog_loader;

  localparam int CPB = 8;
  localparam int AW  = 2;
  localparam int CAP = 4;

  logic          clk  = 1'b0;
  logic          Rst  = 1'b1;
  logic          rx   = 1'b1;
  logic          prog = 1'b0;
  logic          imem_en;
  logic          imem_prog_ena;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din;
  logic [AW:0]   word_count;
  logic          full;
  logic          frame_err;

  uart_prog_loader #(
    .CLKS_PER_BIT(CPB),
    .ADDR_W      (AW)
  ) dut (
    .clk          (clk),
    .Rst          (Rst),
    .rx           (rx),
    .prog         (prog),
    .imem_en      (imem_en),
    .imem_prog_ena(imem_prog_ena),
    .imem_addr    (imem_addr),
    .imem_din     (imem_din),
    .word_count   (word_count),
    .full         (full),
    .frame_err    (frame_err)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model: what the loader has absorbed, and the writes still owed.
  bit            m_prog = 1'b0;
  int            m_idx, m_addr, m_count;
  bit            m_full, m_ferr;
  logic [31:0]   m_word;
  logic [31:0]   last_word, prev_word;
  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_din_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    m_idx = 0; m_addr = 0; m_count = 0; m_full = 1'b0; m_ferr = 1'b0; m_word = '0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ferr = 1'b1;
      return;
    end
    if (!m_prog || m_full) return;
    m_word[8*m_idx +: 8] = b;
    if (m_idx == 3) begin
      exp_addr_q.push_back(AW'(m_addr));
      exp_din_q.push_back(m_word);
      prev_word = last_word;
      last_word = m_word;
      m_addr++;
      m_count++;
      m_idx = 0;
      if (m_count == CAP) m_full = 1'b1;
    end else begin
      m_idx++;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    model_byte(b, stop_ok);
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    if (gap > 0) tick(gap * CPB);
  endtask

  task automatic set_prog(input bit v);
    if (v && !m_prog) model_clear();
    if (!v) m_idx = 0;
    m_prog = v;
    prog   = v;
    tick(3);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_word_count"}, 32'(word_count), m_count);
    chk({tag, "_full"}, 32'(full), 32'(m_full));
    chk({tag, "_frame_err"}, 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_imem_en"}, 32'(imem_en), 0);
    chk({tag, "_prog_ena"}, 32'(imem_prog_ena), 0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 0);
    chk({tag, "_imem_din"}, imem_din, 0);
    chk({tag, "_word_count"}, 32'(word_count), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_frame_err"}, 32'(frame_err), 0);
  endtask

  // Per-cycle compare: strobes agree, pulses are single and match the owed writes, values hold between.
  logic          prev_en;
  logic [AW-1:0] hold_addr;
  logic [31:0]   hold_din;

  always @(negedge clk) begin
    if (!Rst) begin
      prev_en   = 1'b0;
      hold_addr = '0;
      hold_din  = '0;
    end else begin
      chk("strobe_pair", 32'(imem_prog_ena), 32'(imem_en));
      if (imem_en) begin
        chk("single_pulse", 32'(prev_en), 0);
        if (exp_din_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: addr %0d din 0x%0h, no write expected", imem_addr, imem_din);
        end else begin
          hold_addr = exp_addr_q.pop_front();
          hold_din  = exp_din_q.pop_front();
          chk("write_addr", 32'(imem_addr), 32'(hold_addr));
          chk("write_din", imem_din, hold_din);
        end
      end else begin
        chk("hold_addr", 32'(imem_addr), 32'(hold_addr));
        chk("hold_din", imem_din, hold_din);
      end
      prev_en = imem_en;
    end
  end

  initial begin
    logic [7:0] seq[8];
    seq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    model_clear();
    last_word = '0;
    prev_word = '0;

    #5 Rst = 1'b0;
    #20;
    check_reset("reset");
    tick(1);
    Rst = 1'b1;
    tick(4);

    // Basic word
    set_prog(1'b1);
    send_byte(8'h13, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    send_byte(8'h00, 1'b1, 1);
    tick(CPB);
    chk("basic_model_word", last_word, 32'h0000_0013);
    check_status("basic");

    // Reset mid-frame, then a clean word
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      tick(CPB);
    end
    Rst = 1'b0;
    #1;
    check_reset("midreset");
    model_clear();
    exp_addr_q.delete();
    exp_din_q.delete();
    tick(3);
    rx  = 1'b1;
    Rst = 1'b1;
    tick(2 * CPB);
    send_byte(8'hA5, 1'b1, 1);
    send_byte(8'h5A, 1'b1, 1);
    send_byte(8'hC3, 1'b1, 1);
    send_byte(8'h3C, 1'b1, 1);
    tick(CPB);
    chk("post_reset_model_word", last_word, 32'h3CC3_5AA5);
    check_status("post_reset");

    // Sequential words, back-to-back frames
    set_prog(1'b0);
    set_prog(1'b1);
    for (int i = 0; i < 8; i++) send_byte(seq[i], 1'b1, (i == 7) ? 1 : 0);
    tick(CPB);
    chk("seq_model_word0", prev_word, 32'h0010_0093);
    chk("seq_model_word1", last_word, 32'h0020_80B3);
    check_status("sequential");

    // Framing error, then glitch
    set_prog(1'b0);
    set_prog(1'b1);
    send_byte(8'h77, 1'b0, 1);
    check_status("frame_err");
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b1, 0);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 1);
    tick(CPB);
    chk("ferr_model_word", last_word, 32'h4433_2211);
    check_status("after_ferr");
    set_prog(1'b0);
    set_prog(1'b1);
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(4 * CPB);
    check_status("glitch");
    send_byte(8'hDE, 1'b1, 0);
    send_byte(8'hAD, 1'b1, 0);
    send_byte(8'hBE, 1'b1, 0);
    send_byte(8'hEF, 1'b1, 1);
    tick(CPB);
    chk("glitch_model_word", last_word, 32'hEFBE_ADDE);
    check_status("after_glitch");

    // prog gating and partial-word discard
    set_prog(1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 8'h40), 1'b1, 1);
    check_status("gated");
    set_prog(1'b1);
    send_byte(8'hF0, 1'b1, 1);
    send_byte(8'hF1, 1'b1, 1);
    set_prog(1'b0);
    set_prog(1'b1);
    send_byte(8'h01, 1'b1, 0);
    send_byte(8'h02, 1'b1, 0);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'h04, 1'b1, 1);
    tick(CPB);
    chk("partial_model_word", last_word, 32'h0403_0201);
    check_status("partial");

    // Fill the memory
    set_prog(1'b0);
    set_prog(1'b1);
    for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b1, int'($urandom_range(0, 1)));
    tick(2 * CPB);
    chk("full_model_count", m_count, CAP);
    check_status("full");

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      int n;
      set_prog(1'b0);
      set_prog(1'b1);
      n = int'($urandom_range(1, 14));
      for (int k = 0; k < n; k++) begin
        bit ok;
        ok = ($urandom_range(0, 7) != 0);
        send_byte(8'($urandom), ok, ok ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2)));
        if ($urandom_range(0, 9) == 0) begin
          set_prog(1'b0);
          if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1, 1);
          set_prog(1'b1);
        end
      end
      tick(2 * CPB);
      check_status("random");
    end

    tick(4 * CPB);
    chk("writes_drained", exp_din_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
